// File: rtl/snn_pkg.sv
// Shared types and widths for the spiking-network readout blocks.
package snn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        CMP   = 2'd2
    } state_t;

    localparam int CNT_W_DEFAULT = 8;
    // Wide enough to index a window of up to 2^16 enabled cycles.
    localparam int WIN_W = 17;

endpackage

// File: rtl/spike_argmax.sv
// Combinational argmax over per-channel spike counts, with tie and silent flags.
module spike_argmax
    import snn_pkg::*;
#(
    parameter int N_CH  = 2,
    parameter int CNT_W = CNT_W_DEFAULT,
    parameter int IDX_W = 1
) (
    input  logic [N_CH-1:0][CNT_W-1:0] counts,
    output logic [IDX_W-1:0]           winner,
    output logic [CNT_W-1:0]           max_count,
    output logic                       tie,
    output logic                       silent
);

    int hits;

    always_comb begin
        winner    = '0;
        max_count = '0;
        hits      = 0;
        // Strict compare keeps the lowest index when several channels share the maximum.
        for (int i = 0; i < N_CH; i++) begin
            if (counts[i] > max_count) begin
                max_count = counts[i];
                winner    = IDX_W'(i);
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            if (counts[i] == max_count) hits = hits + 1;
        end
        silent = (max_count == '0);
        tie    = !silent && (hits >= 2);
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Windowed spike-count readout: counts spikes per channel over WIN_LEN enabled
// cycles and reports the winning channel through a valid/ready result slot.
module spike_rate_decoder
    import snn_pkg::*;
#(
    parameter int N_CH    = 2,
    parameter int CNT_W   = CNT_W_DEFAULT,
    parameter int WIN_LEN = 200,
    localparam int IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              enable,
    input  logic [N_CH-1:0]   spike_in,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [IDX_W-1:0]  res_winner,
    output logic [CNT_W-1:0]  res_count,
    output logic              res_tie,
    output logic              res_silent,
    output logic              overrun
);

    localparam logic [WIN_W-1:0] LAST_CYCLE = WIN_W'(WIN_LEN - 1);

    state_t                        state;
    logic [N_CH-1:0][CNT_W-1:0]    cnt;
    logic [N_CH-1:0][CNT_W-1:0]    snap;
    logic [N_CH-1:0][CNT_W-1:0]    cnt_next;
    logic [WIN_W-1:0]              win_cnt;

    logic [IDX_W-1:0]              am_winner;
    logic [CNT_W-1:0]              am_count;
    logic                          am_tie;
    logic                          am_silent;

    // Saturating per-channel increment; a counter at all-ones ignores spikes.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            cnt_next[i] = (spike_in[i] && (cnt[i] != '1)) ? cnt[i] + CNT_W'(1) : cnt[i];
        end
    end

    spike_argmax #(
        .N_CH  (N_CH),
        .CNT_W (CNT_W),
        .IDX_W (IDX_W)
    ) u_argmax (
        .counts    (snap),
        .winner    (am_winner),
        .max_count (am_count),
        .tie       (am_tie),
        .silent    (am_silent)
    );

    // Handshake: a result transfers on any posedge where res_valid and res_ready
    // are both high; a CMP load on that same edge replaces it without overrun.
    always_ff @(posedge clk) begin
        if (resetn) begin
            state      <= IDLE;
            cnt        <= '0;
            snap       <= '0;
            win_cnt    <= '0;
            res_valid  <= 1'b0;
            res_winner <= '0;
            res_count  <= '0;
            res_tie    <= 1'b0;
            res_silent <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (res_valid && res_ready) res_valid <= 1'b0;

            if (state == CMP) begin
                if (!res_valid || res_ready) begin
                    res_valid  <= 1'b1;
                    res_winner <= am_winner;
                    res_count  <= am_count;
                    res_tie    <= am_tie;
                    res_silent <= am_silent;
                end else begin
                    overrun <= 1'b1;
                end
            end

            // Counting runs in every state, so CMP doubles as cycle 0 of the next window.
            if (enable) begin
                if (win_cnt == LAST_CYCLE) begin
                    snap    <= cnt_next;
                    cnt     <= '0;
                    win_cnt <= '0;
                    state   <= CMP;
                end else begin
                    cnt     <= cnt_next;
                    win_cnt <= win_cnt + WIN_W'(1);
                    state   <= COUNT;
                end
            end else if (state != IDLE) begin
                state <= COUNT;
            end
        end
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: two instances (CNT_W=8 and CNT_W=4) share stimulus
// and are compared each cycle against a window-sum reference model.
module tb_spike_rate_decoder;

    localparam int WIN = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       res_ready;
    logic [1:0] spike_in;
    logic [1:0] res_valid, res_winner, res_tie, res_silent, overrun;
    logic [7:0] count0;
    logic [3:0] count1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spike_rate_decoder #(.N_CH(2), .CNT_W(8), .WIN_LEN(WIN)) dut0 (
        .clk(clk), .resetn(rst), .enable(enable), .spike_in(spike_in),
        .res_valid(res_valid[0]), .res_ready(res_ready), .res_winner(res_winner[0:0]),
        .res_count(count0), .res_tie(res_tie[0]), .res_silent(res_silent[0]),
        .overrun(overrun[0])
    );

    spike_rate_decoder #(.N_CH(2), .CNT_W(4), .WIN_LEN(WIN)) dut1 (
        .clk(clk), .resetn(rst), .enable(enable), .spike_in(spike_in),
        .res_valid(res_valid[1]), .res_ready(res_ready), .res_winner(res_winner[1:1]),
        .res_count(count1), .res_tie(res_tie[1]), .res_silent(res_silent[1]),
        .overrun(overrun[1])
    );

    // Reference model: raw spike sums per window, saturated only when a result is formed.
    int sums [2];
    int win_pos;
    bit pend;
    int p_win [2], p_cnt [2], p_tie [2], p_sil [2];
    int s_v [2], s_win [2], s_cnt [2], s_tie [2], s_sil [2], s_ovr [2];
    logic [7:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            sums[k] = 0;
            p_win[k] = 0; p_cnt[k] = 0; p_tie[k] = 0; p_sil[k] = 0;
            s_v[k] = 0; s_win[k] = 0; s_cnt[k] = 0; s_tie[k] = 0; s_sil[k] = 0; s_ovr[k] = 0;
        end
        win_pos = 0;
        pend    = 0;
        exp_q.delete();
    endtask

    task automatic form_results();
        for (int inst = 0; inst < 2; inst++) begin
            int cap, best, hits;
            int c [2];
            cap = (inst == 0) ? 255 : 15;
            for (int k = 0; k < 2; k++) c[k] = (sums[k] > cap) ? cap : sums[k];
            best = (c[1] > c[0]) ? 1 : 0;
            hits = 0;
            for (int k = 0; k < 2; k++) if (c[k] == c[best]) hits++;
            p_cnt[inst] = c[best];
            p_sil[inst] = (c[best] == 0) ? 1 : 0;
            p_win[inst] = (c[best] == 0) ? 0 : best;
            p_tie[inst] = (hits >= 2 && c[best] > 0) ? 1 : 0;
        end
    endtask

    task automatic check_all();
        chk("valid0",  res_valid[0],  s_v[0]);
        chk("valid1",  res_valid[1],  s_v[1]);
        chk("winner0", res_winner[0], s_win[0]);
        chk("winner1", res_winner[1], s_win[1]);
        chk("count0",  count0,        s_cnt[0]);
        chk("count1",  count1,        s_cnt[1]);
        chk("tie0",    res_tie[0],    s_tie[0]);
        chk("tie1",    res_tie[1],    s_tie[1]);
        chk("silent0", res_silent[0], s_sil[0]);
        chk("silent1", res_silent[1], s_sil[1]);
        chk("ovr0",    overrun[0],    s_ovr[0]);
        chk("ovr1",    overrun[1],    s_ovr[1]);
    endtask

    // Drive one cycle, advance the model across the edge, then compare #1 after it.
    task automatic step(input logic en, input logic [1:0] sp, input logic rdy, input logic r);
        logic [7:0] pre_cnt;
        rst       = r;
        enable    = en;
        spike_in  = sp;
        res_ready = rdy;
        pre_cnt   = count0;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            for (int inst = 0; inst < 2; inst++) begin
                if (s_v[inst] != 0 && rdy) begin
                    s_v[inst] = 0;
                    if (inst == 0) begin
                        if (exp_q.size() == 0) chk("sb_empty", 1, 0);
                        else chk("sb_xfer_count", pre_cnt, exp_q.pop_front());
                    end
                end
                if (pend) begin
                    if (s_v[inst] == 0) begin
                        s_v[inst]   = 1;
                        s_win[inst] = p_win[inst];
                        s_cnt[inst] = p_cnt[inst];
                        s_tie[inst] = p_tie[inst];
                        s_sil[inst] = p_sil[inst];
                        if (inst == 0) exp_q.push_back(8'(p_cnt[0]));
                    end else begin
                        s_ovr[inst] = 1;
                    end
                end
            end
            pend = 0;
            if (en) begin
                for (int k = 0; k < 2; k++) sums[k] += sp[k] ? 1 : 0;
                win_pos++;
                if (win_pos == WIN) begin
                    form_results();
                    pend    = 1;
                    win_pos = 0;
                    for (int k = 0; k < 2; k++) sums[k] = 0;
                end
            end
        end
        #1;
        check_all();
    endtask

    function automatic logic [1:0] pat(input int kind, input int c);
        logic [1:0] sp;
        case (kind)
            0:       sp = {(c % 4 == 0), 1'b1};
            1:       sp = (c < 8 && c % 2 == 0) ? 2'b11 : 2'b00;
            2:       sp = 2'b00;
            4:       sp = 2'b10;
            default: sp = 2'($urandom_range(0, 3));
        endcase
        return sp;
    endfunction

    task automatic run_win(input int kind, input logic rdy, input int from, input int to);
        for (int c = from; c <= to; c++) step(1'b1, pat(kind, c), rdy, 1'b0);
    endtask

    initial begin
        model_reset();
        rst = 1'b1; enable = 1'b0; spike_in = 2'b00; res_ready = 1'b0;

        step(1'b0, 2'b00, 1'b0, 1'b1);
        step(1'b0, 2'b00, 1'b0, 1'b1);
        chk("reset_valid", res_valid, 2'b00);

        // ch0 every cycle, ch1 every 4th cycle
        run_win(0, 1'b1, 0, 15);
        chk("w1_not_yet", res_valid[0], 1'b0);
        run_win(1, 1'b1, 0, 0);
        chk("w1_valid", res_valid[0], 1'b1);
        chk("w1_count", count0, 8'd16);
        chk("w1_winner", res_winner[0], 1'b0);
        chk("w1_count_sat4", count1, 4'd15);
        run_win(1, 1'b1, 1, 15);

        // Four spikes on each channel: tie
        run_win(2, 1'b1, 0, 0);
        chk("tie_flag", res_tie[0], 1'b1);
        chk("tie_count", count0, 8'd4);
        run_win(2, 1'b1, 1, 15);

        // Silent window, then hold the slot across two more windows
        run_win(3, 1'b0, 0, 0);
        chk("silent_flag", res_silent[0], 1'b1);
        chk("silent_count", count0, 8'd0);
        run_win(3, 1'b0, 1, 15);
        run_win(3, 1'b0, 0, 15);
        run_win(3, 1'b0, 0, 0);
        chk("ovr_set", overrun[0], 1'b1);
        chk("ovr_held_silent", res_silent[0], 1'b1);
        run_win(3, 1'b1, 1, 1);
        run_win(3, 1'b1, 2, 2);
        chk("after_xfer_valid", res_valid[0], 1'b0);
        run_win(3, 1'b1, 3, 15);

        // Pause for 10 cycles mid-window; spikes while paused must not count
        run_win(3, 1'b1, 0, 7);
        for (int i = 0; i < 10; i++) step(1'b0, 2'b11, 1'b1, 1'b0);
        run_win(3, 1'b1, 8, 15);

        // ch1 every cycle: saturates at 15 in the 4-bit instance
        run_win(4, 1'b1, 0, 15);
        run_win(3, 1'b1, 0, 0);
        chk("sat_count", count1, 4'd15);
        chk("sat_winner", res_winner[1], 1'b1);
        chk("unsat_count", count0, 8'd16);
        run_win(3, 1'b1, 1, 15);

        // Reset at window cycle 9 while a result is pending
        run_win(3, 1'b0, 0, 15);
        run_win(3, 1'b0, 0, 8);
        chk("pre_rst_valid", res_valid[0], 1'b1);
        step(1'b1, 2'b11, 1'b0, 1'b1);
        chk("rst_valid", res_valid, 2'b00);
        chk("rst_ovr", overrun, 2'b00);
        run_win(3, 1'b1, 0, 15);
        run_win(3, 1'b1, 0, 1);

        // Randomized enable/ready/spike traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spike_rate_decoder.md
# spike_rate_decoder

Readout stage placed directly downstream of the spiking network's output layer. It counts spikes per output neuron over a fixed window of enabled cycles, then reports the neuron with the highest count (the winner) together with its count, a tie flag and a silent flag. Results leave through a valid/ready handshake to the host or control logic.

## Interface

Parameters:
- `N_CH`, default 2: number of output-neuron spike lines (neuron7, neuron8).
- `CNT_W`, default 8: width of each per-channel spike counter.
- `WIN_LEN`, default 200: window length in enabled cycles, legal range 1..2^16.

Ports:
- `clk`, in, 1: single clock; all logic on posedge.
- `resetn`, in, 1: reset, synchronous, active-high (asserted = 1) despite the name.
- `enable`, in, 1: counting enable; window cycles advance only while high.
- `spike_in`, in, N_CH: one-cycle spike pulses from the output layer, bit i = channel i.
- `res_valid`, out, 1: result available.
- `res_ready`, in, 1: consumer accepts the result.
- `res_winner`, out, clog2(N_CH) (min 1): index of the winning channel.
- `res_count`, out, CNT_W: spike count of the winner.
- `res_tie`, out, 1: more than one channel shares the maximum (non-zero) count.
- `res_silent`, out, 1: all channel counts are zero.
- `overrun`, out, 1: sticky; a window completed while the previous result was unaccepted.

## Operation

- FSM states are IDLE, COUNT and CMP.
  - IDLE: entered on reset; go to COUNT on the first cycle with `enable`=1, and that cycle counts as window cycle 0.
  - COUNT: per enabled cycle, `cnt[i] += spike_in[i]`, saturating at 2^CNT_W-1; `win_cnt` increments.
  - COUNT with `enable`=0: counters and `win_cnt` hold (window paused), no state change.
  - COUNT, final cycle: on the enabled cycle with `win_cnt`==WIN_LEN-1, the spikes of that cycle go into the snapshot (`snap[i]` = `cnt[i]` + `spike_in[i]`, saturated). On the same edge, `cnt` and `win_cnt` clear to 0 and state moves to CMP.
  - CMP, one cycle: the argmax over `snap` loads the result registers if the output slot is free (`res_valid`=0, or accepted this cycle). Otherwise the new result is discarded and `overrun` is set. Return to COUNT.
  - CMP counts normally: if `enable`=1 in CMP, that cycle is window cycle 0 of the next window. Windows run back-to-back with no lost spikes.
- Argmax rules:
  - winner = lowest index holding the maximum count.
  - `res_tie` = 1 if at least 2 channels equal that maximum and the maximum is > 0.
  - `res_silent` = 1 if the maximum is 0; then winner = 0, count = 0, tie = 0.
- Handshake:
  - Transfer occurs on a posedge with `res_valid` & `res_ready`.
  - `res_valid` drops on the next cycle unless CMP loads a new result on the same edge; in that case it stays 1 with the new data.
  - Result outputs are stable while `res_valid`=1 and not accepted.
- `overrun` clears only on reset.
- Reset mid-operation: the partial window and snapshot are discarded, the pending result is dropped.

## Timing

- Reset values: `res_valid`=0, `res_winner`=0, `res_count`=0, `res_tie`=0, `res_silent`=0, `overrun`=0. Internally, state=IDLE and all counters are 0.
- Latency: a spike on the final window cycle N is reflected in a result with `res_valid`=1 from cycle N+2. That is one edge into the snapshot and CMP, plus one edge for the result registers.
- Saturation: a counter at max ignores further spikes; there is no wrap-around.
- `WIN_LEN`=1: every enabled cycle is a final cycle. CMP counts the following cycle, so results issue every cycle that `enable` stays high.
- Simultaneous events:
  - Acceptance and a new CMP load on the same edge: the load wins and `overrun` stays 0.
  - Spikes on all channels in the same cycle: each channel's counter increments.

## Structure

- The shared package `snn_pkg` holds:
  - the FSM state enum (`IDLE`, `COUNT`, `CMP`);
  - the default `CNT_W`;
  - the `WIN_W`=17 width for `win_cnt`.
- Sub-module `spike_argmax`: a combinational N_CH×CNT_W max/index/tie/silent tree, instantiated in CMP-stage logic.

## Test plan

All scenarios use `WIN_LEN`=16 and N_CH=2.

- Reset, then `enable`=1 with ch0 spiking every cycle and ch1 every 4th cycle. Expect the result 2 cycles after window cycle 15: winner=0, count=16, tie=0, silent=0.
- 4 spikes on each channel within a window. Expect winner=0, count=4, tie=1. With no spikes at all, expect silent=1, winner=0, count=0.
- Hold `res_ready`=0 across two windows. Expect the first result held unchanged and `overrun`=1 after the second window's CMP. Raise `res_ready`; expect one transfer, then `res_valid`=0.
- Drop `enable` for 10 cycles mid-window. Expect the result delayed by exactly 10 cycles with counts unchanged. Spikes during `enable`=0 are not counted.
- Use CNT_W=4 with ch1 spiking on all 16 cycles. Expect count saturated at 15, winner=1.
- Assert `resetn` at window cycle 9 with `res_valid` high. The next cycle must show all outputs at reset values. The next window restarts from cycle 0 and counts only post-reset spikes.
